// File: rtl/tx_byte_sched_if.sv
// Requester/shift-register side bundle of tx_byte_sched.
// The master modport drives requests and bytes; the slave modport is the scheduler.
interface tx_byte_sched_if;
  logic [1:0] req;
  logic [7:0] byte_in0;
  logic [7:0] byte_in1;
  logic [1:0] valid;
  logic [1:0] last;
  logic [1:0] ready;
  logic [1:0] grant;
  logic       sr_load;
  logic       sr_shift;
  logic [7:0] sr_data;
  logic       tx_active;
  logic       eop;
  logic       err_underrun;

  modport master (
    output req, byte_in0, byte_in1, valid, last,
    input  ready, grant, sr_load, sr_shift, sr_data, tx_active, eop, err_underrun
  );

  modport slave (
    input  req, byte_in0, byte_in1, valid, last,
    output ready, grant, sr_load, sr_shift, sr_data, tx_active, eop, err_underrun
  );
endinterface

// File: rtl/tx_byte_sched.sv
// Two-requester fixed-priority byte scheduler feeding a parallel-to-serial shift register.
// All outputs are registered; strobes appear in the cycle after the deciding edge.
module tx_byte_sched #(
  parameter int unsigned BIT_CYCLES = 8
) (
  input logic            clk,
  input logic            rst,
  tx_byte_sched_if.slave bus
);
  localparam int unsigned TW = 8;
  localparam int unsigned CW = 3;

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [CW-1:0]   bitcnt_q, bitcnt_d;
  logic            last_q, last_d;
  logic [1:0]      grant_q, grant_d;
  logic [1:0]      ready_q, ready_d;
  logic            sr_load_q, sr_load_d;
  logic            sr_shift_q, sr_shift_d;
  logic [7:0]      sr_data_q, sr_data_d;
  logic            tx_active_q, tx_active_d;
  logic            eop_q, eop_d;
  logic            err_q, err_d;

  logic            g_valid_c;
  logic            g_last_c;
  logic [7:0]      g_byte_c;

  // Granted-port view; grant_q is one-hot whenever it is consulted
  assign g_valid_c = grant_q[1] ? bus.valid[1] : bus.valid[0];
  assign g_last_c  = grant_q[1] ? bus.last[1]  : bus.last[0];
  assign g_byte_c  = grant_q[1] ? bus.byte_in1 : bus.byte_in0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      bitcnt_q    <= '0;
      last_q      <= 1'b0;
      grant_q     <= '0;
      ready_q     <= '0;
      sr_load_q   <= 1'b0;
      sr_shift_q  <= 1'b0;
      sr_data_q   <= '0;
      tx_active_q <= 1'b0;
      eop_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bitcnt_q    <= bitcnt_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      ready_q     <= ready_d;
      sr_load_q   <= sr_load_d;
      sr_shift_q  <= sr_shift_d;
      sr_data_q   <= sr_data_d;
      tx_active_q <= tx_active_d;
      eop_q       <= eop_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bitcnt_d    = bitcnt_q;
    last_d      = last_q;
    grant_d     = grant_q;
    ready_d     = '0;
    sr_load_d   = 1'b0;
    sr_shift_d  = 1'b0;
    sr_data_d   = sr_data_q;
    tx_active_d = tx_active_q;
    eop_d       = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|bus.req) state_d = S_ARB;
      end
      S_ARB: begin
        if (bus.req[0]) begin
          grant_d = 2'b01;
          state_d = S_LOAD;
        end else if (bus.req[1]) begin
          grant_d = 2'b10;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (g_valid_c) begin
          sr_load_d   = 1'b1;
          ready_d     = grant_q;
          sr_data_d   = g_byte_c;
          last_d      = g_last_c;
          tx_active_d = 1'b1;
          timer_d     = TW'(BIT_CYCLES - 1);
          bitcnt_d    = '0;
          state_d     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else if (bitcnt_q != CW'(7)) begin
          sr_shift_d = 1'b1;
          timer_d    = TW'(BIT_CYCLES - 1);
          bitcnt_d   = bitcnt_q + CW'(1);
        end else if (last_q) begin
          eop_d   = 1'b1;
          state_d = S_DONE;
        end else if (g_valid_c) begin
          // Gapless follow-on byte: reload in place of the boundary shift
          sr_load_d = 1'b1;
          ready_d   = grant_q;
          sr_data_d = g_byte_c;
          last_d    = g_last_c;
          timer_d   = TW'(BIT_CYCLES - 1);
          bitcnt_d  = '0;
        end else begin
          err_d       = 1'b1;
          grant_d     = '0;
          tx_active_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      S_DONE: begin
        grant_d     = '0;
        tx_active_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.ready        = ready_q;
  assign bus.grant        = grant_q;
  assign bus.sr_load      = sr_load_q;
  assign bus.sr_shift     = sr_shift_q;
  assign bus.sr_data      = sr_data_q;
  assign bus.tx_active    = tx_active_q;
  assign bus.eop          = eop_q;
  assign bus.err_underrun = err_q;
endmodule

// File: tb/tb_tx_byte_sched.sv
// Directed bench for tx_byte_sched: packet vectors on a BIT_CYCLES=8 and a BIT_CYCLES=2 instance,
// plus hand sequences for mid-packet reset and post-reset idle behaviour.
module tb_tx_byte_sched;
  localparam int MAXC = 600;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tx_byte_sched_if bus0 ();
  tx_byte_sched_if bus1 ();

  tx_byte_sched #(.BIT_CYCLES(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus0));
  tx_byte_sched #(.BIT_CYCLES(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct packed {
    logic [1:0] ready;
    logic [1:0] grant;
    logic       ld;
    logic       sh;
    logic [7:0] data;
    logic       act;
    logic       eop;
    logic       err;
  } obs_t;

  typedef struct {
    int              d;
    logic [1:0]      req;
    logic [1:0]      req_run;
    logic [1:0]      req_after;
    int              port;
    int              nbytes;
    int              avail;
    int              vdelay;
    logic [2:0][7:0] bytes;
    logic [1:0]      exp_grant;
    int              exp_loads;
    int              exp_shifts;
    int              exp_eop;
    int              exp_err;
  } vec_t;

  int n_cmp  = 0;
  int n_miss = 0;

  task automatic check(input string nm, input string what, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s %s: got %0d expected %0d", nm, what, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic [1:0] rq, input logic [7:0] b0,
                       input logic [7:0] b1, input logic [1:0] vl, input logic [1:0] ls);
    if (d == 0) begin
      bus0.req = rq; bus0.byte_in0 = b0; bus0.byte_in1 = b1; bus0.valid = vl; bus0.last = ls;
    end else begin
      bus1.req = rq; bus1.byte_in0 = b0; bus1.byte_in1 = b1; bus1.valid = vl; bus1.last = ls;
    end
  endtask

  task automatic sample(input int d, output obs_t o);
    if (d == 0) begin
      o.ready = bus0.ready; o.grant = bus0.grant; o.ld = bus0.sr_load; o.sh = bus0.sr_shift;
      o.data = bus0.sr_data; o.act = bus0.tx_active; o.eop = bus0.eop; o.err = bus0.err_underrun;
    end else begin
      o.ready = bus1.ready; o.grant = bus1.grant; o.ld = bus1.sr_load; o.sh = bus1.sr_shift;
      o.data = bus1.sr_data; o.act = bus1.tx_active; o.eop = bus1.eop; o.err = bus1.err_underrun;
    end
  endtask

  function automatic vec_t mk(input int d, input logic [1:0] rq, input logic [1:0] rr,
                              input logic [1:0] ra, input int port, input int nb, input int av,
                              input int vd, input logic [2:0][7:0] by, input logic [1:0] eg,
                              input int el, input int es, input int ee, input int er);
    vec_t v;
    v.d = d; v.req = rq; v.req_run = rr; v.req_after = ra; v.port = port; v.nbytes = nb;
    v.avail = av; v.vdelay = vd; v.bytes = by; v.exp_grant = eg; v.exp_loads = el;
    v.exp_shifts = es; v.exp_eop = ee; v.exp_err = er;
    return v;
  endfunction

  // Runs one packet with a byte-feeding requester model and checks timing against the vector
  task automatic run_pkt(input vec_t v, input string nm);
    obs_t       o;
    int         bc, t0, idx, gcnt, vcyc, end_cyc, post;
    int         loads, shifts, eop_off, err_off, off;
    int         bad_sh, bad_ld, bad_data, bad_proto, bad_gnt;
    logic [7:0] prev, bg, b0, b1;
    logic [1:0] rq, vl, ls, pm, g_at_load, bi;
    logic       pv, pl, allowed, done;
    bc = (v.d == 0) ? 8 : 2;
    pm = 2'(1 << v.port);
    t0 = -1; idx = 0; gcnt = 0; vcyc = -1; end_cyc = -1; post = -1;
    loads = 0; shifts = 0; eop_off = -1; err_off = -1;
    bad_sh = 0; bad_ld = 0; bad_data = 0; bad_proto = 0; bad_gnt = 0;
    prev = 8'h00; g_at_load = 2'b00; done = 1'b0;
    for (int cyc = 0; cyc < MAXC; cyc++) begin
      @(negedge clk);
      sample(v.d, o);
      if (cyc == 0) prev = o.data;
      if (end_cyc >= 0) begin
        post = int'({o.grant, o.act});
        done = 1'b1;
        break;
      end
      if (o.ld && t0 < 0) begin
        t0 = cyc;
        g_at_load = o.grant;
      end
      off = cyc - t0;
      bi = 2'((idx > 2) ? 2 : idx);
      if (o.ld) begin
        loads++;
        if ((off % (8 * bc)) != 0) bad_ld++;
        if (o.data != v.bytes[bi]) bad_data++;
      end else if (o.data != prev) begin
        bad_data++;
      end
      prev = o.data;
      if (o.sh) begin
        shifts++;
        if (t0 < 0 || (off % bc) != 0 || (off % (8 * bc)) == 0) bad_sh++;
      end
      if (o.ld && o.sh) bad_proto++;
      if (o.ready != (o.ld ? pm : 2'b00)) bad_proto++;
      if (o.grant == 2'b11) bad_proto++;
      if (o.act && o.grant != v.exp_grant) bad_gnt++;
      if (o.eop) begin
        eop_off = (t0 >= 0) ? off : -2;
        if (!o.act) bad_proto++;
      end
      if (o.err) begin
        err_off = (t0 >= 0) ? off : -2;
        if (o.act || o.grant != 2'b00) bad_proto++;
      end
      if (o.ready[v.port]) idx++;
      if (o.eop || o.err) end_cyc = cyc;
      if (o.grant != 2'b00) gcnt++;
      allowed = (v.vdelay == 0) || (gcnt >= v.vdelay);
      rq = (end_cyc >= 0) ? v.req_after : ((t0 >= 0) ? v.req_run : v.req);
      pv = allowed && (idx < v.avail);
      if (pv && vcyc < 0) vcyc = cyc;
      bi = 2'((idx > 2) ? 2 : idx);
      bg = v.bytes[bi];
      pl = (idx == v.nbytes - 1);
      b0 = 8'hEE; b1 = 8'hEE;
      if (v.port == 0) begin
        vl = {1'b1, pv}; ls = {1'b1, pl}; b0 = bg;
      end else begin
        vl = {pv, 1'b1}; ls = {pl, 1'b1}; b1 = bg;
      end
      drive(v.d, rq, b0, b1, vl, ls);
    end
    check(nm, "complete", int'(done), 1);
    check(nm, "grant", int'(g_at_load), int'(v.exp_grant));
    check(nm, "loads", loads, v.exp_loads);
    check(nm, "shifts", shifts, v.exp_shifts);
    check(nm, "load_timing_bad", bad_ld, 0);
    check(nm, "shift_timing_bad", bad_sh, 0);
    check(nm, "sr_data_bad", bad_data, 0);
    check(nm, "protocol_bad", bad_proto, 0);
    check(nm, "grant_hold_bad", bad_gnt, 0);
    check(nm, "eop_offset", eop_off, v.exp_eop);
    check(nm, "err_offset", err_off, v.exp_err);
    check(nm, "idle_after", post, 0);
    if (v.vdelay > 0) check(nm, "load_latency", t0, vcyc + 1);
  endtask

  vec_t vt[10];

  initial begin
    obs_t o;
    int   shc, evs;
    logic reached;

    // d, req, req_run, req_after, port, nbytes, avail, vdelay, bytes[2:0], grant, loads, shifts, eop, err
    vt[0] = mk(0, 2'b10, 2'b00, 2'b00, 1, 1, 1, 0,  {8'h00, 8'h00, 8'hA5}, 2'b10, 1, 7,  64, -1);
    vt[1] = mk(0, 2'b10, 2'b00, 2'b00, 1, 3, 3, 0,  {8'h03, 8'h02, 8'h01}, 2'b10, 3, 21, 192, -1);
    vt[2] = mk(0, 2'b10, 2'b00, 2'b00, 1, 2, 1, 0,  {8'h00, 8'h9C, 8'h6B}, 2'b10, 1, 7,  -1, 64);
    vt[3] = mk(0, 2'b11, 2'b11, 2'b11, 0, 1, 1, 0,  {8'h00, 8'h00, 8'h3C}, 2'b01, 1, 7,  64, -1);
    vt[4] = mk(0, 2'b11, 2'b11, 2'b10, 0, 1, 1, 0,  {8'h00, 8'h00, 8'hC3}, 2'b01, 1, 7,  64, -1);
    vt[5] = mk(0, 2'b10, 2'b00, 2'b00, 1, 2, 2, 0,  {8'h00, 8'hA5, 8'h5A}, 2'b10, 2, 14, 128, -1);
    vt[6] = mk(1, 2'b01, 2'b00, 2'b00, 0, 3, 3, 0,  {8'h33, 8'h22, 8'h11}, 2'b01, 3, 21, 48, -1);
    vt[7] = mk(1, 2'b10, 2'b00, 2'b00, 1, 1, 1, 0,  {8'h00, 8'h00, 8'h80}, 2'b10, 1, 7,  16, -1);
    vt[8] = mk(0, 2'b01, 2'b00, 2'b00, 0, 1, 1, 20, {8'h00, 8'h00, 8'h7E}, 2'b01, 1, 7,  64, -1);
    vt[9] = mk(1, 2'b01, 2'b00, 2'b00, 0, 3, 2, 0,  {8'hCC, 8'hBB, 8'hAA}, 2'b01, 2, 14, -1, 32);

    drive(0, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
    drive(1, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    sample(0, o);
    check("reset", "outs_bc8", int'(o), 0);
    sample(1, o);
    check("reset", "outs_bc2", int'(o), 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_pkt(vt[i], $sformatf("vec%0d", i));

    // Reset during the third bit of a byte on the BIT_CYCLES=8 instance
    drive(0, 2'b01, 8'h5A, 8'h00, 2'b01, 2'b00);
    shc = 0; evs = 0; reached = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      sample(0, o);
      if (o.eop || o.err) evs++;
      if (o.sh) shc++;
      if (shc == 2) begin
        reached = 1'b1;
        break;
      end
    end
    check("midrst", "reached_bit3", int'(reached), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sample(0, o);
    check("midrst", "outs_zero", int'(o), 0);
    drive(0, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      sample(0, o);
      if (o.eop || o.err || o.grant != 2'b00 || o.act) evs++;
    end
    check("midrst", "silent_idle", evs, 0);

    run_pkt(vt[0], "post_rst");
    run_pkt(vt[7], "post_rst_bc2");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end
endmodule

// File: doc/tx_byte_sched.md
TX_BYTE_SCHED -- requirements
Module: tx_byte_sched

Interface
REQ-001 SHALL have parameter BIT_CYCLES, default 8, meaning clocks per serial bit period; legal values are 2 to 255.
REQ-002 SHALL have the port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have the ports req[1:0], input, 2 bits: per-requester packet request; index 0 is control, index 1 is data.
REQ-005 SHALL have the ports byte_in0[7:0] and byte_in1[7:0], input, 8 bits each: per-requester byte to transmit.
REQ-006 SHALL have the ports valid[1:0] and last[1:0], input, 2 bits each: byte_inN is valid; byte_inN is the final byte of its packet.
REQ-007 SHALL have the port ready[1:0], output, 2 bits: one-cycle byte-accept pulse to each requester.
REQ-008 SHALL have the port grant[1:0], output, 2 bits: one-hot owner of the current packet.
REQ-009 SHALL have the ports sr_load and sr_shift, output, 1 bit each: load and shift strobes to the parallel-to-serial shift register.
REQ-010 SHALL have the port sr_data[7:0], output, 8 bits: parallel byte presented to the shift register.
REQ-011 SHALL have the port tx_active, output, 1 bit: high from the first sr_load through the eop cycle.
REQ-012 SHALL have the ports eop and err_underrun, output, 1 bit each: one-cycle pulses.

Function
REQ-013 SHALL implement states IDLE, ARB, LOAD, SHIFT and DONE.
REQ-014 IDLE SHALL go to ARB on the cycle after any req bit is sampled high.
REQ-015 ARB SHALL grant requester 0 if req[0] is high, else requester 1, with fixed priority; grant SHALL be registered and held until DONE or abort.
REQ-016 LOAD SHALL wait, with no timeout, for valid of the granted port.
REQ-017 On that cycle in LOAD, sr_load, ready[g] and tx_active SHALL assert, sr_data SHALL take byte_in[g], the last flag SHALL be captured, and the state SHALL move to SHIFT.
REQ-018 Byte timing SHALL follow from a load at cycle t: sr_shift pulses at t+k*BIT_CYCLES for k=1..7, and the byte boundary falls at t+8*BIT_CYCLES.
REQ-019 The bit timer SHALL be a down-counter reloaded to BIT_CYCLES-1 on every load or shift, and the bit counter SHALL count 0..7.
REQ-020 At the byte boundary with the captured last flag set, the block SHALL go to DONE with no sr_shift or sr_load.
REQ-021 At the byte boundary with last clear and valid[g] high, the block SHALL issue sr_load plus ready[g] on that same cycle with no sr_shift, giving a gapless back-to-back byte, and stay in SHIFT.
REQ-022 At the byte boundary with last clear and valid[g] low (underrun), the block SHALL pulse err_underrun, clear grant and tx_active, and go to IDLE with no eop.
REQ-023 DONE SHALL pulse eop for one cycle with tx_active still high, then clear grant and go to IDLE.
REQ-024 Arbitration SHALL occur only at packet boundaries; req changes mid-packet SHALL be ignored.
REQ-025 A requester dropping req mid-packet SHALL NOT abort the packet.
REQ-026 sr_load and sr_shift SHALL never assert in the same cycle.
REQ-027 ready SHALL assert only coincident with sr_load and only on the granted port.
REQ-028 sr_data SHALL hold its value between loads.
REQ-029 Valid or last on a non-granted port SHALL be ignored.
REQ-030 When both requesters are requesting back-to-back, requester 0 SHALL re-win ARB after DONE; starvation of requester 1 is accepted behaviour.

Reset
REQ-031 While rst is high at a rising edge, the state SHALL become IDLE and the bit timer and bit counter SHALL clear.
REQ-032 Under reset, grant, ready, sr_load, sr_shift, tx_active, eop and err_underrun SHALL be 0 and sr_data SHALL be 8'h00 on the next cycle.
REQ-033 Reset mid-packet SHALL abort silently with no eop and no err_underrun.
REQ-034 The first ARB after reset SHALL require a req sampled after rst deasserts.

Verification
REQ-035 Single byte, BIT_CYCLES=8: req[1], valid[1], last[1], byte 8'hA5 -> grant=2'b10, sr_load once with sr_data=A5, 7 sr_shift pulses spaced 8 clocks apart, eop 64 clocks after sr_load.
REQ-036 Three-byte packet (8'h01, 8'h02, 8'h03 last), valid held high -> sr_load at t, t+64 and t+128, no idle bit period between bytes, 21 sr_shift pulses in total, eop at t+192.
REQ-037 Contention, with req=2'b11 asserted in the same cycle -> requester 0's packet completes, then requester 1 is granted in the next ARB; grant is never 2'b11.
REQ-038 Underrun: two-byte packet with valid[1] dropped before the first boundary -> err_underrun pulse at t+64, no eop, state back in IDLE, tx_active low.
REQ-039 rst asserted at the 3rd bit of a byte -> all outputs 0 the next cycle; a new req afterwards starts a clean packet with correct timing.
REQ-040 BIT_CYCLES=2 corner case: shift spacing of 2 clocks and back-to-back loads 16 clocks apart; sr_load and sr_shift are never coincident.
